// File: rtl/cam_tx_pkg.sv
// Shared types and constants for the camera transmitter emulator:
// FSM state encoding, pattern codes and the colour-bar palette.
package cam_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBACK  = 3'd2,
    ST_LINE   = 3'd3,
    ST_HBLANK = 3'd4,
    ST_VFRONT = 3'd5
  } state_t;

  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_RAMP  = 2'd1;
  localparam logic [1:0] PAT_ADDR  = 2'd2;
  localparam logic [1:0] PAT_CHECK = 2'd3;

  // Width of the pixel coordinates handed to the pattern generator.
  localparam int COORD_W = 8;

  // Colour bars, left to right, as 12-bit {R,G,B}.
  localparam logic [11:0] BAR_COLORS [8] = '{
    12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000
  };

  // Largest of four timing counts; sizes the shared blanking counter.
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/cam_tx_pattern.sv
// Combinational test-pattern generator: maps pixel (x, y) and the
// pattern code latched at frame start to a 12-bit {R,G,B} value.
module cam_tx_pattern
  import cam_tx_pkg::*;
#(
  parameter int SCREEN_X = 160
) (
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic [1:0]         i_pat,
  output logic [11:0]        o_pix
);

  logic [2:0] w_bar_idx;

  // Each bar is SCREEN_X/8 pixels wide.
  assign w_bar_idx = 3'(i_x / COORD_W'(SCREEN_X / 8));

  // Pick the pixel colour for the selected pattern.
  always_comb begin
    o_pix = 12'h000;
    case (i_pat)
      PAT_BARS:  o_pix = BAR_COLORS[w_bar_idx];
      PAT_RAMP:  o_pix = {3{i_x[7:4]}};
      // Linear pixel address computed at 15 bits, low 12 bits kept.
      PAT_ADDR:  o_pix = 12'(15'(i_x) + 15'(i_y) * 15'(SCREEN_X));
      PAT_CHECK: o_pix = (i_x[3] ^ i_y[3]) ? 12'hFFF : 12'h000;
      default:   o_pix = 12'h000;
    endcase
  end

endmodule

// File: rtl/cam_tx_emulator.sv
// OV7670-style parallel camera transmitter. Generates pclk = clk/2 and
// QQVGA RGB444 frames (vsync, href, byte stream) from internal patterns.
// All frame state moves on pclk falling edges so data is stable around
// every pclk rise seen by the receiver.
module cam_tx_emulator
  import cam_tx_pkg::*;
#(
  parameter int SCREEN_X    = 160,
  parameter int SCREEN_Y    = 120,
  parameter int VSYNC_PCLK  = 16,
  parameter int VBP_PCLK    = 32,
  parameter int HBLANK_PCLK = 32,
  parameter int VFP_PCLK    = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] pat_sel,
  output logic       CAM_pclk,
  output logic       CAM_vsync,
  output logic       CAM_href,
  output logic [7:0] CAM_px_data,
  output logic       frame_done,
  output logic [2:0] dbg_state
);

  localparam int SLOT_W = $clog2(2 * SCREEN_X);
  localparam int LINE_W = $clog2(SCREEN_Y);
  localparam int CNT_W  = $clog2(max4(VSYNC_PCLK, VBP_PCLK, HBLANK_PCLK, VFP_PCLK));

  state_t            r_state;
  logic              r_ph;
  logic [CNT_W-1:0]  r_cnt;
  logic [SLOT_W-1:0] r_slot;
  logic [LINE_W-1:0] r_line;
  logic [1:0]        r_pat;
  logic              r_vsync;
  logic              r_href;
  logic [7:0]        r_data;
  logic              r_done;

  logic              w_fall;
  logic [SLOT_W-1:0] w_slot_next;
  logic [LINE_W-1:0] w_pat_y;
  logic [11:0]       w_pix;
  logic [7:0]        w_byte;

  // A fall edge is any clk edge where pclk is currently high.
  assign w_fall = r_ph;

  // Data is registered, so the pattern is looked up for the slot that
  // will be on the bus after this edge: the next slot inside a line,
  // slot 0 of the current line from VBACK, slot 0 of the next line from HBLANK.
  assign w_slot_next = (r_state == ST_LINE) ? r_slot + SLOT_W'(1) : '0;
  assign w_pat_y     = (r_state == ST_HBLANK) ? r_line + LINE_W'(1) : r_line;

  // Even slot carries {0,R}, odd slot carries {G,B}.
  assign w_byte = w_slot_next[0] ? w_pix[7:0] : {4'h0, w_pix[11:8]};

  cam_tx_pattern #(
    .SCREEN_X(SCREEN_X)
  ) u_pattern (
    .i_x  (COORD_W'(w_slot_next[SLOT_W-1:1])),
    .i_y  (COORD_W'(w_pat_y)),
    .i_pat(r_pat),
    .o_pix(w_pix)
  );

  // Phase bit, frame FSM, counters and registered sync/data outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ph    <= 1'b0;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_slot  <= '0;
      r_line  <= '0;
      r_pat   <= PAT_BARS;
      r_vsync <= 1'b0;
      r_href  <= 1'b0;
      r_data  <= 8'h00;
      r_done  <= 1'b0;
    end else begin
      r_ph   <= ~r_ph;
      r_done <= 1'b0;
      if (w_fall) begin
        case (r_state)
          ST_IDLE: begin
            r_vsync <= 1'b0;
            r_href  <= 1'b0;
            r_data  <= 8'h00;
            if (enable) begin
              r_state <= ST_VSYNC;
              r_vsync <= 1'b1;
              r_pat   <= pat_sel;
              r_line  <= '0;
              r_cnt   <= '0;
            end
          end
          ST_VSYNC: begin
            if (r_cnt == CNT_W'(VSYNC_PCLK - 1)) begin
              r_state <= ST_VBACK;
              r_vsync <= 1'b0;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_VBACK: begin
            if (r_cnt == CNT_W'(VBP_PCLK - 1)) begin
              r_state <= ST_LINE;
              r_href  <= 1'b1;
              r_data  <= w_byte;
              r_slot  <= '0;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_LINE: begin
            if (r_slot == SLOT_W'(2 * SCREEN_X - 1)) begin
              r_state <= ST_HBLANK;
              r_href  <= 1'b0;
              r_data  <= 8'h00;
              r_cnt   <= '0;
            end else begin
              r_slot <= w_slot_next;
              r_data <= w_byte;
            end
          end
          ST_HBLANK: begin
            if (r_cnt == CNT_W'(HBLANK_PCLK - 1)) begin
              r_cnt <= '0;
              if (r_line == LINE_W'(SCREEN_Y - 1)) begin
                r_state <= ST_VFRONT;
              end else begin
                r_state <= ST_LINE;
                r_line  <= w_pat_y;
                r_href  <= 1'b1;
                r_data  <= w_byte;
                r_slot  <= '0;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_VFRONT: begin
            if (r_cnt == CNT_W'(VFP_PCLK - 1)) begin
              r_done <= 1'b1;
              r_cnt  <= '0;
              // enable is only looked at here, so frames are never cut short.
              if (enable) begin
                r_state <= ST_VSYNC;
                r_vsync <= 1'b1;
                r_pat   <= pat_sel;
                r_line  <= '0;
              end else begin
                r_state <= ST_IDLE;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign CAM_pclk    = r_ph;
  assign CAM_vsync   = r_vsync;
  assign CAM_href    = r_href;
  assign CAM_px_data = r_data;
  assign frame_done  = r_done;
  assign dbg_state   = r_state;

endmodule
